// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    LEN_LO,
    LEN_HI,
    DATA,
    DONE
  } load_state_t;

  localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling, glitch-filtered start.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     state, state_next;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          half_hit, full_hit, fall;
  logic          stop_hit_c;

  assign half_hit = (cnt == HALF_M1);
  assign full_hit = (cnt == FULL_M1);
  assign fall     = rx_prev & ~rx_sync;

  // Two-flop synchronizer plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= RX_IDLE;
    else       state <= state_next;
  end

  // Receiver next-state logic
  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:  if (fall) state_next = RX_START;
      RX_START: if (half_hit) state_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full_hit && bit_idx == 3'd7) state_next = RX_STOP;
      RX_STOP:  if (full_hit) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  // Stop-bit sample point decode
  always_comb begin
    stop_hit_c = (state == RX_STOP) && full_hit;
  end

  // Bit-period counter, bit index, shift register and result strobes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      byte_data  <= '0;
    end else begin
      if (state == RX_IDLE || state_next != state || full_hit) cnt <= '0;
      else                                                     cnt <= cnt + CW'(1);
      if (state == RX_START) bit_idx <= '0;
      if (state == RX_DATA && full_hit) begin
        shreg   <= {rx_sync, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      byte_valid <= stop_hit_c & rx_sync;
      frame_err  <= stop_hit_c & ~rx_sync;
      if (stop_hit_c && rx_sync) byte_data <= shreg;
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a length-prefixed program image from UART into IMEM, then releases the core.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  uart_rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rstn,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CW           = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH        = 2 ** ADDR_WIDTH;

  load_state_t   state, state_next;
  logic          rx_valid, rx_ferr;
  logic [7:0]    rx_data;
  logic [7:0]    len_lo;
  logic [15:0]   len;
  logic [15:0]   len_full;
  logic [CW-1:0] word_cnt;
  logic [1:0]    byte_idx;
  logic [23:0]   word_buf;
  logic          last_byte, last_word, len_bad;
  logic          busy_c, release_c, ferr_c, write_c;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rstn       (rstn),
    .rx         (uart_rx),
    .byte_valid (rx_valid),
    .byte_data  (rx_data),
    .frame_err  (rx_ferr)
  );

  assign len_full  = {rx_data, len_lo};
  assign len_bad   = 32'(len_full) > DEPTH;
  assign last_byte = (byte_idx == 2'(WORD_BYTES - 1));
  assign last_word = (32'(word_cnt) + 32'd1) == 32'(len);

  // Loader state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= WAIT_SYNC;
    else       state <= state_next;
  end

  // Loader next-state logic
  always_comb begin
    state_next = state;
    case (state)
      WAIT_SYNC: if (rx_valid && rx_data == SYNC_BYTE) state_next = LEN_LO;
      LEN_LO: begin
        if (rx_ferr)       state_next = WAIT_SYNC;
        else if (rx_valid) state_next = LEN_HI;
      end
      LEN_HI: begin
        if (rx_ferr) state_next = WAIT_SYNC;
        else if (rx_valid) begin
          if (len_full == 16'd0) state_next = DONE;
          else if (len_bad)      state_next = WAIT_SYNC;
          else                   state_next = DATA;
        end
      end
      DATA: begin
        if (rx_ferr)                                state_next = WAIT_SYNC;
        else if (rx_valid && last_byte && last_word) state_next = DONE;
      end
      DONE:    state_next = DONE;
      default: state_next = WAIT_SYNC;
    endcase
  end

  // Loader output decode, registered below
  always_comb begin
    busy_c    = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
    release_c = (state == DONE);
    ferr_c    = busy_c && rx_ferr;
    write_c   = (state == DATA) && rx_valid && last_byte;
  end

  // Byte assembler, word counter and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rstn   <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      len_lo     <= '0;
      len        <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
    end else begin
      imem_we  <= write_c;
      busy     <= busy_c;
      cpu_rstn <= release_c;
      if (ferr_c || (state == LEN_HI && rx_valid && len_bad)) err <= 1'b1;
      if (write_c) begin
        imem_addr  <= word_cnt[ADDR_WIDTH-1:0];
        imem_wdata <= {rx_data, word_buf};
      end
      if (ferr_c) begin
        word_cnt <= '0;
        byte_idx <= '0;
        word_buf <= '0;
      end else if (rx_valid) begin
        case (state)
          LEN_LO: len_lo <= rx_data;
          LEN_HI: begin
            len      <= len_full;
            word_cnt <= '0;
            byte_idx <= '0;
          end
          DATA: begin
            byte_idx <= byte_idx + 2'd1;
            if (last_byte) word_cnt <= word_cnt + CW'(1);
            else           word_buf[{byte_idx, 3'b000} +: 8] <= rx_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
